id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-stage operand forwarding. Sits directly upstream of the ALU.
- Captures decoded instruction fields each cycle and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU's op1/op2/alu_ctrl.
- Detects load-use hazards, handles pipeline stall and flush, and passes memory/writeback control to the downstream stage.

Parameters:
WIDTH, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  freeze stage contents (downstream backpressure)
flush  in  1  squash stage contents (taken branch/jump)
id_valid  in  1  decode slot holds an instruction
id_pc  in  WIDTH  instruction PC
id_rs1_data, id_rs2_data  in  WIDTH  register-file read data
id_imm  in  WIDTH  sign-extended immediate
id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_AW  register indices
id_alu_ctrl  in  4  ALU opcode (ALU encoding)
id_alu_src  in  1  1: op2 = immediate
id_op1_pc  in  1  1: op1 = PC (AUIPC/JAL)
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
exm_reg_write  in  1  EX/MEM writes a register
exm_rd  in  REG_AW  EX/MEM destination
exm_result  in  WIDTH  EX/MEM ALU result
mwb_reg_write  in  1  MEM/WB writes a register
mwb_rd  in  REG_AW  MEM/WB destination
mwb_result  in  WIDTH  MEM/WB writeback value
load_use  out  1  combinational: hold fetch/decode this cycle
ex_valid  out  1  EX slot valid
op1, op2  out  WIDTH  ALU operands
alu_ctrl  out  4  registered ALU opcode
ex_store_data  out  WIDTH  forwarded rs2 value for stores
ex_pc  out  WIDTH  registered PC
ex_rd  out  REG_AW  registered destination
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered controls, gated by ex_valid

Behaviour:
- Reset (async, reset_n=0): all registers 0. Reset value of every output is 0, except op1/op2/ex_store_data, which equal forwarded 0 = 0.
- Register update priority each rising edge:
  1. flush: load bubble (valid=0, all control bits 0, data fields 0).
  2. stall: hold. Exception: rs1/rs2 data registers capture their currently forwarded values, so a producer retiring during the stall is not lost.
  3. load_use: load bubble; decode holds upstream.
  4. Otherwise: load all id_* fields; valid=id_valid. When id_valid=0, controls are loaded as 0.
- Forwarding (combinational, on registered rs1/rs2 addr and data), per source operand:
  - If exm_reg_write && exm_rd!=0 && exm_rd==addr, use exm_result.
  - Else if mwb_reg_write && mwb_rd!=0 && mwb_rd==addr, use mwb_result.
  - Else use the registered data.
  - EX/MEM beats MEM/WB. x0 is never forwarded.
- Operand select:
  - op1 = ex_op1_pc ? ex_pc : fwd_rs1.
  - op2 = ex_alu_src ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- load_use = ex_valid && ex_mem_read && ex_rd!=0 && id_valid && (ex_rd==id_rs1_addr || ex_rd==id_rs2_addr).
  - Asserted regardless of stall.
  - Masked to 0 when flush=1.
- Latency: 1 cycle from id_* to ex_*. Forwarding adds no cycles. A load-use hazard costs exactly 1 bubble.
- Simultaneous flush+stall: flush wins.
- Simultaneous stall+load_use: stall wins. load_use stays high until the stall releases, then the bubble is inserted.
- Reset mid-operation: immediate clear. The first edge after release loads normally.
- Wrap-around: arithmetic is done by the ALU, not here. No width growth; all fields are passed unmodified.

Test Plan:
- Basic pass-through: id_rs1_data=5, id_rs2_data=7, alu_ctrl=0000, no hazards -> next cycle op1=5, op2=7, alu_ctrl=0000, ex_valid=1.
- Forward priority: ex rs1=x3; exm_rd=3 with result 0x11; mwb_rd=3 with result 0x22 -> op1=0x11. Drop exm_reg_write -> op1=0x22. Set exm_rd=0 with write -> no forward.
- Load-use: EX holds lw x4 (mem_read=1, rd=4); ID has add with rs2=x4 -> load_use=1. Next edge ex_valid=0 and all controls 0. Following edge loads the add, with op2 forwarded from mwb_result.
- Stall capture: stall=1 for 3 cycles while mwb forwards 0x55 to rs1 in cycle 1 only -> op1 remains 0x55 in cycles 2-3 and after release.
- Flush vs stall: flush=1 and stall=1 together -> bubble loaded, ex_valid=0, load_use=0.
- Async reset: assert reset_n=0 mid-cycle with ex_valid=1 -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding,
// load-use detection, stall and flush handling.
module id_ex_stage #(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [WIDTH-1:0]  id_pc,
   input  logic [WIDTH-1:0]  id_rs1_data,
   input  logic [WIDTH-1:0]  id_rs2_data,
   input  logic [WIDTH-1:0]  id_imm,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic [3:0]        id_alu_ctrl,
   input  logic              id_alu_src,
   input  logic              id_op1_pc,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              exm_reg_write,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic [WIDTH-1:0]  exm_result,
   input  logic              mwb_reg_write,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic [WIDTH-1:0]  mwb_result,
   output logic              load_use,
   output logic              ex_valid,
   output logic [WIDTH-1:0]  op1,
   output logic [WIDTH-1:0]  op2,
   output logic [3:0]        alu_ctrl,
   output logic [WIDTH-1:0]  ex_store_data,
   output logic [WIDTH-1:0]  ex_pc,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg
);

   typedef struct packed {
      logic              valid;
      logic [WIDTH-1:0]  pc;
      logic [WIDTH-1:0]  rs1_data;
      logic [WIDTH-1:0]  rs2_data;
      logic [WIDTH-1:0]  imm;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [REG_AW-1:0] rd;
      logic [3:0]        alu_ctrl;
      logic              alu_src;
      logic              op1_pc;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
   } id_ex_t;

   id_ex_t ex_q;
   id_ex_t ex_d;
   id_ex_t id_in;

   logic [WIDTH-1:0] fwd_rs1;
   logic [WIDTH-1:0] fwd_rs2;
   logic             rs_hit;

   function automatic logic [WIDTH-1:0] fwd(
      input logic [REG_AW-1:0] addr,
      input logic [WIDTH-1:0]  data
   );
      logic [WIDTH-1:0] r;
      r = data;
      if (exm_reg_write && exm_rd != '0 && exm_rd == addr)
         r = exm_result;
      else if (mwb_reg_write && mwb_rd != '0 && mwb_rd == addr)
         r = mwb_result;
      return r;
   endfunction

   always_comb begin
      fwd_rs1 = fwd(ex_q.rs1_addr, ex_q.rs1_data);
      fwd_rs2 = fwd(ex_q.rs2_addr, ex_q.rs2_data);
   end

   assign rs_hit = (ex_q.rd == id_rs1_addr) ||
                   (ex_q.rd == id_rs2_addr);

   assign load_use = !flush && ex_q.valid && ex_q.mem_read &&
                     ex_q.rd != '0 && id_valid && rs_hit;

   always_comb begin
      id_in            = '0;
      id_in.valid      = id_valid;
      id_in.pc         = id_pc;
      id_in.rs1_data   = id_rs1_data;
      id_in.rs2_data   = id_rs2_data;
      id_in.imm        = id_imm;
      id_in.rs1_addr   = id_rs1_addr;
      id_in.rs2_addr   = id_rs2_addr;
      id_in.rd         = id_rd_addr;
      id_in.alu_ctrl   = id_alu_ctrl;
      id_in.alu_src    = id_alu_src;
      id_in.op1_pc     = id_op1_pc;
      id_in.reg_write  = id_valid & id_reg_write;
      id_in.mem_read   = id_valid & id_mem_read;
      id_in.mem_write  = id_valid & id_mem_write;
      id_in.mem_to_reg = id_valid & id_mem_to_reg;
   end

   // On stall the operand data keeps absorbing forwarded values so a
   // producer that retires while we are frozen is not lost.
   always_comb begin
      ex_d = ex_q;
      priority case (1'b1)
         flush: ex_d = '0;
         stall: begin
            ex_d.rs1_data = fwd_rs1;
            ex_d.rs2_data = fwd_rs2;
         end
         load_use: ex_d = '0;
         default:  ex_d = id_in;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ex_q <= '0;
      else
         ex_q <= ex_d;
   end

   assign ex_valid      = ex_q.valid;
   assign op1           = ex_q.op1_pc ? ex_q.pc : fwd_rs1;
   assign op2           = ex_q.alu_src ? ex_q.imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign alu_ctrl      = ex_q.alu_ctrl;
   assign ex_pc         = ex_q.pc;
   assign ex_rd         = ex_q.rd;
   assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
   assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
   assign ex_mem_write  = ex_q.valid & ex_q.mem_write;
   assign ex_mem_to_reg = ex_q.valid & ex_q.mem_to_reg;

endmodule
